// File: rtl/simon_iter_cipher_if.sv
// Handshake bundle between the SIMON engine, the key/data host and the result consumer.
// The engine takes the slave view and the host side takes the master view.
interface simon_iter_cipher_if #(
   parameter int WORD = 32,
   parameter int KEYW = 4
);
   logic                   key_valid;
   logic                   key_ready;
   logic [KEYW*WORD-1:0]   key_in;
   logic                   in_valid;
   logic                   in_ready;
   logic                   in_decrypt;
   logic [2*WORD-1:0]      in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WORD-1:0]      out_data;
   logic                   key_loaded;

   modport slave (
      input  key_valid, key_in, in_valid, in_decrypt, in_data, out_ready,
      output key_ready, in_ready, out_valid, out_data, key_loaded
   );

   modport master (
      output key_valid, key_in, in_valid, in_decrypt, in_data, out_ready,
      input  key_ready, in_ready, out_valid, out_data, key_loaded
   );
endinterface

// File: rtl/simon_iter_cipher.sv
// Iterative SIMON 2N/mN engine. The key is expanded once into a round-key store, then
// blocks are encrypted or decrypted UNROLL rounds per clock behind valid/ready handshakes.
module simon_iter_cipher #(
   parameter int WORD   = 32,
   parameter int KEYW   = 4,
   parameter int ROUNDS = 44,
   parameter int ZSEQ   = 3,
   parameter int UNROLL = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   simon_iter_cipher_if.slave   bus
);
   localparam int KW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam int NCYC = ROUNDS / UNROLL;
   localparam int RW   = (NCYC > 1) ? $clog2(NCYC) : 1;

   if (KEYW < 2 || KEYW > 4) begin : g_bad_keyw
      $error("simon_iter_cipher: KEYW must be 2, 3 or 4");
   end
   if (ZSEQ < 0 || ZSEQ > 4) begin : g_bad_zseq
      $error("simon_iter_cipher: ZSEQ must be 0..4");
   end
   if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
      $error("simon_iter_cipher: UNROLL must divide ROUNDS");
   end

   // Bit 61 holds the first sequence element, so index i is read at ZS[61-i].
   function automatic logic [61:0] z_seq(input int j);
      case (j)
         0:       return 62'b11111010001001010110000111001101111101000100101011000011100110;
         1:       return 62'b10001110111110010011000010110101000111011111001001100001011010;
         2:       return 62'b10101111011100000011010010011000101000010001111110010110110011;
         3:       return 62'b11011011101011000110010111100000010010001010011100110100001111;
         4:       return 62'b11010001111001101011011000100000010111000011001010010011101111;
         default: return '0;
      endcase
   endfunction

   localparam logic [61:0] ZS = z_seq(ZSEQ);

   function automatic logic [WORD-1:0] rol(input logic [WORD-1:0] a, input int r);
      return (a << r) | (a >> (WORD - r));
   endfunction

   function automatic logic [WORD-1:0] f_round(input logic [WORD-1:0] a);
      return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
   endfunction

   typedef enum logic [2:0] {S_NOKEY, S_KEXP, S_READY, S_BUSY, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [WORD-1:0]   ks_q [ROUNDS];
   logic [KW-1:0]     kidx_q, kidx_d;
   logic [5:0]        zidx_q, zidx_d;
   logic [RW-1:0]     rnd_q, rnd_d;
   logic [WORD-1:0]   x_q, x_d, y_q, y_d;
   logic              dec_q, dec_d;
   logic              key_rdy, in_rdy, out_vld, key_hs;
   logic [WORD-1:0]   k_new, rx, ry, tmp;
   logic [KW-1:0]     kix;

   always_comb begin
      k_new = rol(ks_q[kidx_q - KW'(1)], WORD - 3);
      if (KEYW == 4) k_new = k_new ^ ks_q[kidx_q - KW'(3)];
      k_new = k_new ^ rol(k_new, WORD - 1);
      k_new = k_new ^ ~ks_q[kidx_q - KW'(KEYW)] ^ WORD'(3) ^ WORD'(ZS[6'd61 - zidx_q]);
   end

   // Decryption walks the same store from the top entry downward.
   always_comb begin
      rx  = x_q;
      ry  = y_q;
      tmp = '0;
      kix = '0;
      for (int u = 0; u < UNROLL; u++) begin
         kix = KW'(rnd_q) * KW'(UNROLL) + KW'(u);
         if (dec_q) begin
            tmp = ry;
            ry  = rx ^ f_round(ry) ^ ks_q[KW'(ROUNDS - 1) - kix];
            rx  = tmp;
         end else begin
            tmp = rx;
            rx  = ry ^ f_round(rx) ^ ks_q[kix];
            ry  = tmp;
         end
      end
   end

   // NOTE: every output of this block is given a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      kidx_d  = kidx_q;
      zidx_d  = zidx_q;
      rnd_d   = rnd_q;
      x_d     = x_q;
      y_d     = y_q;
      dec_d   = dec_q;
      key_rdy = 1'b0;
      in_rdy  = 1'b0;
      out_vld = 1'b0;
      case (state_q)
         S_NOKEY: begin
            key_rdy = 1'b1;
            if (bus.key_valid) begin
               state_d = S_KEXP;
               kidx_d  = KW'(KEYW);
               zidx_d  = '0;
            end
         end
         S_KEXP: begin
            kidx_d = kidx_q + KW'(1);
            zidx_d = (zidx_q == 6'd61) ? 6'd0 : zidx_q + 6'd1;
            if (kidx_q == KW'(ROUNDS - 1)) state_d = S_READY;
         end
         S_READY: begin
            key_rdy = 1'b1;
            in_rdy  = 1'b1;
            if (bus.key_valid) begin
               state_d = S_KEXP;
               kidx_d  = KW'(KEYW);
               zidx_d  = '0;
            end else if (bus.in_valid) begin
               state_d = S_BUSY;
               x_d     = bus.in_data[2*WORD-1:WORD];
               y_d     = bus.in_data[WORD-1:0];
               dec_d   = bus.in_decrypt;
               rnd_d   = '0;
            end
         end
         S_BUSY: begin
            x_d   = rx;
            y_d   = ry;
            rnd_d = rnd_q + RW'(1);
            if (rnd_q == RW'(NCYC - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            out_vld = 1'b1;
            if (bus.out_ready) state_d = S_READY;
         end
         default: state_d = S_NOKEY;
      endcase
   end

   assign key_hs         = bus.key_valid && key_rdy;
   assign bus.key_ready  = key_rdy;
   assign bus.in_ready   = in_rdy;
   assign bus.out_valid  = out_vld;
   assign bus.out_data   = {x_q, y_q};
   assign bus.key_loaded = state_q inside {S_READY, S_BUSY, S_DONE};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_NOKEY;
         kidx_q  <= '0;
         zidx_q  <= '0;
         rnd_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         dec_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kidx_q  <= kidx_d;
         zidx_q  <= zidx_d;
         rnd_q   <= rnd_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dec_q   <= dec_d;
      end
   end

   // NOTE: the key store has no reset; it is only read once key_loaded is set, and reset forces a reload.
   always_ff @(posedge clk) begin
      if (key_hs) begin
         for (int i = 0; i < KEYW; i++) ks_q[KW'(i)] <= bus.key_in[i*WORD +: WORD];
      end else if (state_q == S_KEXP) begin
         ks_q[kidx_q] <= k_new;
      end
   end
endmodule

// File: tb/tb_simon_iter_cipher.sv
// Bench for simon_iter_cipher: SIMON64/128 (UNROLL=1) and SIMON32/64 (UNROLL=4) instances
// checked against a word-level reference model, known-answer vectors and handshake corner cases.
module tb_simon_iter_cipher;
   logic clk = 1'b0;
   logic rst64_n, rst32_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   simon_iter_cipher_if #(.WORD(32), .KEYW(4)) bus64 ();
   simon_iter_cipher_if #(.WORD(16), .KEYW(4)) bus32 ();

   simon_iter_cipher dut64 (.clk(clk), .rst_n(rst64_n), .bus(bus64.slave));
   simon_iter_cipher #(.WORD(16), .KEYW(4), .ROUNDS(32), .ZSEQ(0), .UNROLL(4)) dut32 (
      .clk(clk), .rst_n(rst32_n), .bus(bus32.slave));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // s = 0 selects the 64/128 instance, s = 1 the 32/64 instance.
   function automatic int n_of(input bit s); return s ? 16 : 32; endfunction
   function automatic int t_of(input bit s); return s ? 32 : 44; endfunction
   function automatic int j_of(input bit s); return s ? 0 : 3; endfunction
   function automatic int u_of(input bit s); return s ? 4 : 1; endfunction

   function automatic logic kr(input bit s); return s ? bus32.key_ready  : bus64.key_ready;  endfunction
   function automatic logic ir(input bit s); return s ? bus32.in_ready   : bus64.in_ready;   endfunction
   function automatic logic ov(input bit s); return s ? bus32.out_valid  : bus64.out_valid;  endfunction
   function automatic logic kl(input bit s); return s ? bus32.key_loaded : bus64.key_loaded; endfunction
   function automatic logic [63:0] od(input bit s);
      return s ? {32'h0, bus32.out_data} : bus64.out_data;
   endfunction

   task automatic set_key(input bit s, input logic v, input logic [127:0] k);
      if (s) begin bus32.key_valid = v; bus32.key_in = k[63:0]; end
      else   begin bus64.key_valid = v; bus64.key_in = k;       end
   endtask

   task automatic set_in(input bit s, input logic v, input logic d, input logic [63:0] p);
      if (s) begin bus32.in_valid = v; bus32.in_decrypt = d; bus32.in_data = p[31:0]; end
      else   begin bus64.in_valid = v; bus64.in_decrypt = d; bus64.in_data = p;       end
   endtask

   task automatic set_or(input bit s, input logic v);
      if (s) bus32.out_ready = v; else bus64.out_ready = v;
   endtask

   // ---------------- reference model ----------------
   logic [63:0] mk [72];

   function automatic logic [63:0] msk(input int n); return (64'h1 << n) - 64'h1; endfunction

   function automatic logic [63:0] rotl(input logic [63:0] a, input int r, input int n);
      int rr;
      rr = r % n;
      if (rr == 0) return a & msk(n);
      return ((a << rr) | (a >> (n - rr))) & msk(n);
   endfunction

   function automatic logic [63:0] fm(input logic [63:0] a, input int n);
      return (rotl(a, 1, n) & rotl(a, 8, n)) ^ rotl(a, 2, n);
   endfunction

   function automatic logic zbit(input int j, input int idx);
      logic [61:0] z;
      case (j)
         0:       z = 62'b11111010001001010110000111001101111101000100101011000011100110;
         3:       z = 62'b11011011101011000110010111100000010010001010011100110100001111;
         default: z = '0;
      endcase
      return z[61 - idx];
   endfunction

   task automatic model_expand(input bit s, input logic [127:0] key);
      int n, t;
      logic [63:0] tmp;
      n = n_of(s);
      t = t_of(s);
      for (int i = 0; i < 4; i++) mk[i] = 64'(key >> (i * n)) & msk(n);
      for (int i = 4; i < t; i++) begin
         tmp   = rotl(mk[i-1], n - 3, n) ^ mk[i-3];
         tmp   = tmp ^ rotl(tmp, n - 1, n);
         mk[i] = (~mk[i-4] & msk(n)) ^ tmp ^ 64'(zbit(j_of(s), (i - 4) % 62)) ^ 64'd3;
      end
   endtask

   function automatic logic [63:0] model_run(input bit s, input bit dec, input logic [63:0] p);
      int n, t;
      logic [63:0] x, y, h;
      n = n_of(s);
      t = t_of(s);
      x = (p >> n) & msk(n);
      y = p & msk(n);
      for (int r = 0; r < t; r++) begin
         if (!dec) begin h = x; x = y ^ fm(x, n) ^ mk[r];         y = h; end
         else      begin h = y; y = x ^ fm(y, n) ^ mk[t - 1 - r]; x = h; end
      end
      return (x << n) | y;
   endfunction

   // ---------------- transaction helpers (called and returning at a falling edge) ----------------
   task automatic load_key(input bit s, input logic [127:0] key, input string tag);
      int n;
      set_key(s, 1'b1, key);
      n = 0;
      while (!kr(s) && n < 200) begin @(negedge clk); n++; end
      check({tag, "_key_ready"}, kr(s), 1'b1);
      @(negedge clk);
      set_key(s, 1'b0, key);
      model_expand(s, key);
      n = 0;
      while (!kl(s) && n < 200) begin n++; @(negedge clk); end
      check({tag, "_kexp_len"}, n, t_of(s) - 4);
   endtask

   task automatic run_block(input bit s, input bit dec, input logic [63:0] p, input int hold,
                            input string tag, output logic [63:0] res);
      int n;
      bit bad;
      set_in(s, 1'b1, dec, p);
      set_or(s, 1'b0);
      n = 0;
      while (!ir(s) && n < 200) begin @(negedge clk); n++; end
      check({tag, "_in_ready"}, ir(s), 1'b1);
      @(negedge clk);
      set_in(s, 1'b0, 1'b0, 64'h0);
      n = 0;
      while (!ov(s) && n < 300) begin n++; @(negedge clk); end
      check({tag, "_latency"}, n, t_of(s) / u_of(s));
      res = od(s);
      bad = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         if (od(s) !== res || ir(s) !== 1'b0 || ov(s) !== 1'b1) bad = 1'b1;
      end
      if (hold > 0) check({tag, "_backpressure"}, bad, 1'b0);
      set_or(s, 1'b1);
      @(negedge clk);
      set_or(s, 1'b0);
      check({tag, "_back_to_ready"}, {ov(s), ir(s)}, 2'b01);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [127:0] key, key_b;
      logic [63:0]  p, c, d;
      int           acc;

      rst64_n = 1'b0;
      rst32_n = 1'b0;
      set_key(0, 1'b0, '0); set_in(0, 1'b0, 1'b0, '0); set_or(0, 1'b0);
      set_key(1, 1'b0, '0); set_in(1, 1'b0, 1'b0, '0); set_or(1, 1'b0);
      repeat (3) @(negedge clk);
      rst64_n = 1'b1;
      rst32_n = 1'b1;
      @(negedge clk);
      check("rst64_flags", {kr(0), ir(0), ov(0), kl(0)}, 4'b1000);
      check("rst64_data", od(0), 64'h0);
      check("rst32_flags", {kr(1), ir(1), ov(1), kl(1)}, 4'b1000);

      // Known-answer vectors, with 10 cycles of output backpressure on the first.
      key = 128'h1b1a1918_13121110_0b0a0908_03020100;
      load_key(0, key, "t1");
      run_block(0, 1'b0, 64'h656b696c_20646e75, 10, "t1", c);
      check("t1_kat_encrypt", c, 64'h44c8fc20_b9dfa07a);
      run_block(0, 1'b1, 64'h44c8fc20_b9dfa07a, 0, "t2", d);
      check("t2_kat_decrypt", d, 64'h656b696c_20646e75);

      load_key(1, 128'h1918_1110_0908_0100, "t3");
      run_block(1, 1'b0, 64'h6565_6877, 0, "t3", c);
      check("t3_kat_encrypt", c, 64'hc69b_e9bb);

      // Randomized round trips against the model on both instances.
      for (int k = 0; k < 6; k++) begin
         bit s;
         s   = k[0];
         key = {$urandom(), $urandom(), $urandom(), $urandom()};
         load_key(s, key, "rnd");
         for (int b = 0; b < 2; b++) begin
            p = {$urandom(), $urandom()} & (s ? 64'hffff_ffff : 64'hffff_ffff_ffff_ffff);
            run_block(s, 1'b0, p, 0, "rnd_enc", c);
            check("rnd_encrypt_model", c, model_run(s, 1'b0, p));
            run_block(s, 1'b1, c, 0, "rnd_dec", d);
            check("rnd_decrypt_roundtrip", d, p);
         end
      end

      // Key and block offered together in READY: the key wins, the block waits for it.
      key   = 128'h1b1a1918_13121110_0b0a0908_03020100;
      load_key(0, key, "t5a");
      key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
      p     = {$urandom(), $urandom()};
      set_key(0, 1'b1, key_b);
      set_in(0, 1'b1, 1'b0, p);
      @(negedge clk);
      set_key(0, 1'b0, key_b);
      check("t5_key_wins", {kl(0), ir(0), ov(0)}, 3'b000);
      model_expand(0, key_b);
      acc = 0;
      while (!kl(0) && acc < 200) begin acc++; @(negedge clk); end
      check("t5_kexp_len", acc, 40);
      run_block(0, 1'b0, p, 0, "t5", c);
      check("t5_new_key_result", c, model_run(0, 1'b0, p));

      // Reset in the middle of BUSY aborts everything and demands a new key.
      set_in(0, 1'b1, 1'b0, p);
      acc = 0;
      while (!ir(0) && acc < 200) begin @(negedge clk); acc++; end
      @(negedge clk);
      set_in(0, 1'b0, 1'b0, 64'h0);
      repeat (20) @(negedge clk);
      rst64_n = 1'b0;
      #1;
      check("t6_abort_flags", {ov(0), kl(0), kr(0)}, 3'b001);
      @(negedge clk);
      rst64_n = 1'b1;
      set_in(0, 1'b1, 1'b0, p);
      set_or(0, 1'b1);
      acc = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ir(0) || ov(0) || kl(0)) acc++;
      end
      check("t6_no_block_without_key", acc, 0);
      set_in(0, 1'b0, 1'b0, 64'h0);
      set_or(0, 1'b0);
      load_key(0, key, "t6");
      run_block(0, 1'b0, 64'h656b696c_20646e75, 0, "t6", c);
      check("t6_recovered", c, 64'h44c8fc20_b9dfa07a);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
